// File: rtl/obstacle_spawner.sv
// obstacle_spawner: requests a random X from the generator, spawns an obstacle
// above the screen, steps it down once per frame, and retires it on exit or hit.
// After retiring, it waits a fixed number of frames before the next request.
module obstacle_spawner #(
    parameter int unsigned SIZE_BITS   = 8,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 607,
    parameter int unsigned X_SHIFT     = 1,
    parameter int unsigned OBJ_H       = 32,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned SPAWN_DELAY = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 collision,
    input  logic [SIZE_BITS-1:0] rand_val,
    output logic                 rand_req,
    output logic [10:0]          topLeftX,
    output logic signed [10:0]   topLeftY,
    output logic                 obstacle_active,
    output logic [7:0]           hit_count
);

    // A zero delay is treated as a one-frame delay.
    localparam int unsigned DELAY_EFF = (SPAWN_DELAY == 0) ? 1 : SPAWN_DELAY;
    localparam int unsigned CNT_W     = $clog2(DELAY_EFF + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DELAY_EFF - 1);
    localparam logic [11:0]        SPAWN_Y12  = 12'(0 - OBJ_H);
    localparam logic signed [11:0] SCREEN_H12 = 12'(SCREEN_H);
    localparam logic [11:0]        X_MAX12    = 12'(X_MAX);

    typedef enum logic [2:0] {
        S_WAIT,
        S_REQ,
        S_HOLD,
        S_CAPTURE,
        S_FALL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic              act_q, act_d;
    logic [7:0]        hit_q, hit_d;

    logic [11:0]        x_map;
    logic [10:0]        x_clamp;
    logic signed [11:0] y_step;

    // Next-state and next-output logic for the spawn/fall sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        act_d   = act_q;
        hit_d   = hit_q;

        x_map   = 12'(X_MIN) + (12'(rand_val) << X_SHIFT);
        x_clamp = (x_map > X_MAX12) ? X_MAX12[10:0] : x_map[10:0];
        y_step  = $signed({y_q[10], y_q}) + $signed(12'(SPEED));

        case (state_q)
            S_WAIT: begin
                if (startOfFrame) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_REQ: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                x_d     = x_clamp;
                y_d     = SPAWN_Y12[10:0];
                act_d   = 1'b1;
                state_d = S_FALL;
            end
            S_FALL: begin
                // A hit takes priority over a frame step on the same clock.
                if (collision && act_q) begin
                    act_d   = 1'b0;
                    hit_d   = hit_q + 8'd1;
                    state_d = S_WAIT;
                end else if (startOfFrame) begin
                    y_d = y_step[10:0];
                    if (y_step >= SCREEN_H12) begin
                        act_d   = 1'b0;
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            x_q     <= 11'(X_MIN);
            y_q     <= SPAWN_Y12[10:0];
            act_q   <= 1'b0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
        end
    end

    assign rand_req        = req_q;
    assign topLeftX        = x_q;
    assign topLeftY        = $signed(y_q);
    assign obstacle_active = act_q;
    assign hit_count       = hit_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Testbench for obstacle_spawner: scoreboard of expected spawns and retirements.
module tb_obstacle_spawner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN;
    logic        sof;
    logic        coll;
    logic [7:0]  rv;

    logic        req0, act0, req1, act1;
    logic [10:0] x0, x1;
    logic signed [10:0] y0, y1;
    logic [7:0]  hit0, hit1;

    obstacle_spawner #(.SPAWN_DELAY(2)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(coll),
        .rand_val(rv), .rand_req(req0), .topLeftX(x0), .topLeftY(y0),
        .obstacle_active(act0), .hit_count(hit0)
    );

    obstacle_spawner #(.SPAWN_DELAY(2), .X_SHIFT(2)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(coll),
        .rand_val(rv), .rand_req(req1), .topLeftX(x1), .topLeftY(y1),
        .obstacle_active(act1), .hit_count(hit1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct { int x0; int x1; } spawn_t;
    typedef struct { int y; int hits; } retire_t;
    spawn_t  spawn_q[$];
    retire_t retire_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic act0_prev = 1'b0;
    logic req0_prev = 1'b0;
    logic req1_prev = 1'b0;
    int   req_rise_cyc = 0;
    int   pulses0 = 0;
    int   pulses1 = 0;

    // Monitor: counts request pulses, pops scoreboard entries on spawn/retire.
    always @(negedge clk) begin
        spawn_t  s;
        retire_t r;
        if (req0 && !req0_prev) begin
            pulses0++;
            req_rise_cyc = cyc;
        end
        if (req1 && !req1_prev) pulses1++;
        if (req0_prev) check_eq("req_one_clk", int'(req0), 0);
        if (act0 && !act0_prev) begin
            check_eq("spawn_pending", int'(spawn_q.size() > 0), 1);
            if (spawn_q.size() > 0) begin
                s = spawn_q.pop_front();
                check_eq("spawn_x", int'(x0), s.x0);
                check_eq("spawn_x_shift2", int'(x1), s.x1);
                check_eq("spawn_y", int'(y0), -32);
                check_eq("spawn_y_dut1", int'(y1), -32);
                check_eq("spawn_act_dut1", int'(act1), 1);
                check_eq("spawn_latency", cyc - req_rise_cyc, 3);
            end
        end
        if (!act0 && act0_prev) begin
            check_eq("retire_pending", int'(retire_q.size() > 0), 1);
            if (retire_q.size() > 0) begin
                r = retire_q.pop_front();
                check_eq("retire_y", int'(y0), r.y);
                check_eq("retire_hits", int'(hit0), r.hits);
                check_eq("retire_act_dut1", int'(act1), 0);
                check_eq("retire_hits_dut1", int'(hit1), r.hits);
                check_eq("retire_y_dut1", int'(y1), r.y);
            end
        end
        act0_prev <= act0;
        req0_prev <= req0;
        req1_prev <= req1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int gap);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req"}, int'(req0), 0);
        check_eq({tag, "_x"}, int'(x0), 0);
        check_eq({tag, "_y"}, int'(y0), -32);
        check_eq({tag, "_act"}, int'(act0), 0);
        check_eq({tag, "_hit"}, int'(hit0), 0);
        check_eq({tag, "_x_dut1"}, int'(x1), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        sof    = 1'b0;
        coll   = 1'b0;
        rv     = 8'd0;
        repeat (3) tick();
        check_reset_vals("rst");
        resetN = 1'b1;
        tick();

        // First spawn: rand_val 100 -> X 200 (shift 1) / 400 (shift 2).
        rv = 8'd100;
        frame(10);
        check_eq("req_after_frame1", int'(req0), 0);
        spawn_q.push_back('{200, 400});
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check_eq("req_after_frame2", int'(req0), 1);
        check_eq("act_in_req", int'(act0), 0);
        tick();
        check_eq("req_in_hold", int'(req0), 0);
        tick();
        check_eq("act_in_capture", int'(act0), 0);
        tick();
        check_eq("act_3clk", int'(act0), 1);
        check_eq("x_100", int'(x0), 200);

        // Fall off the bottom: 256 frames at speed 2 reach Y = 480.
        retire_q.push_back('{480, 0});
        repeat (255) frame(2);
        check_eq("y_frame255", int'(y0), 478);
        check_eq("act_frame255", int'(act0), 1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check_eq("y_exit", int'(y0), 480);
        check_eq("act_exit", int'(act0), 0);
        check_eq("hit_exit", int'(hit0), 0);
        tick();

        // Collision outside FALL is ignored.
        coll = 1'b1;
        tick();
        coll = 1'b0;
        check_eq("hit_coll_in_wait", int'(hit0), 0);

        // Clamp case; frames held high through REQ/HOLD/CAPTURE are ignored.
        rv = 8'd255;
        spawn_q.push_back('{510, 607});
        frame(10);
        sof = 1'b1;
        tick();
        check_eq("req_clamp_spawn", int'(req0), 1);
        repeat (3) tick();
        sof = 1'b0;
        check_eq("x_255_shift1", int'(x0), 510);
        check_eq("x_255_clamped", int'(x1), 607);
        check_eq("y_frames_ignored", int'(y0), -32);

        // Collision on the same clock as the exiting frame: collision wins.
        retire_q.push_back('{478, 1});
        repeat (255) frame(2);
        check_eq("y_before_tie", int'(y0), 478);
        sof  = 1'b1;
        coll = 1'b1;
        tick();
        sof  = 1'b0;
        coll = 1'b0;
        check_eq("hit_tie", int'(hit0), 1);
        check_eq("act_tie", int'(act0), 0);
        check_eq("y_tie_hold", int'(y0), 478);

        // Mid-fall collision without a frame pulse.
        rv = 8'd7;
        spawn_q.push_back('{14, 28});
        frame(10);
        frame(10);
        repeat (3) frame(2);
        check_eq("y_midfall", int'(y0), -26);
        retire_q.push_back('{-26, 2});
        coll = 1'b1;
        tick();
        coll = 1'b0;
        check_eq("hit_midfall", int'(hit0), 2);
        check_eq("act_midfall", int'(act0), 0);

        // Asynchronous reset during HOLD.
        rv = 8'd50;
        frame(10);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check_eq("req_before_rst", int'(req0), 1);
        tick();
        #2;
        resetN = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick();
        resetN = 1'b1;
        frame(10);
        check_eq("req_after_rst_frame1", int'(req0), 0);
        check_eq("pulses_before_respawn", pulses0, 4);
        spawn_q.push_back('{100, 200});
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check_eq("req_after_rst_frame2", int'(req0), 1);
        repeat (4) tick();
        check_eq("act_after_rst_spawn", int'(act0), 1);

        check_eq("spawn_q_empty", spawn_q.size(), 0);
        check_eq("retire_q_empty", retire_q.size(), 0);
        check_eq("req_pulses", pulses0, 5);
        check_eq("req_pulses_dut1", pulses1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
